// File: rtl/efpga_top2_pkg.sv
// Shared encodings, LFSR taps and output field layout for the eFPGA top level.
package efpga_top2_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_ADD  = 2'b10,
    OP_XOR  = 2'b11
  } op_e;

  localparam int LFSR_W = 80;
  localparam int TAP_0  = 79;
  localparam int TAP_1  = 78;
  localparam int TAP_2  = 42;
  localparam int TAP_3  = 41;

  localparam int D_LSB     = 0;
  localparam int CTRL_LSB  = 8;
  localparam int ACC_LSB   = 12;
  localparam int EN_BIT    = 20;
  localparam int PHASE_BIT = 21;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
    return {r[LFSR_W-2:0], r[TAP_0] ^ r[TAP_1] ^ r[TAP_2] ^ r[TAP_3]};
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] s);
    return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/efpga_dr_check.sv
// Dual-rail pair checker: flags any bit whose true and false rails agree.
module efpga_dr_check #(
  parameter int W = 1
) (
  input  logic [W-1:0] rail_t,
  input  logic [W-1:0] rail_f,
  output logic         fault
);

  assign fault = |(~(rail_t ^ rail_f));

endmodule

// File: rtl/efpga_top2.sv
// Masked dual-rail I/O boundary around a small byte accumulator datapath,
// with LFSR mask generation, fault detection and a word-serial config loader.
module efpga_top2
  import efpga_top2_pkg::*;
#(
  parameter int INPUT_W = 22,
  parameter int CFG_W   = 92
) (
  input  logic               CLK,
  input  logic               rst_sync_fabric,
  input  logic               rst_sync_rng,
  input  logic               rst_async_full,
  input  logic               resetn,
  input  logic [INPUT_W:0]   O_top_0_t,
  input  logic [INPUT_W:0]   O_top_0_f,
  input  logic [INPUT_W:0]   O_top_1_t,
  input  logic [INPUT_W:0]   O_top_1_f,
  input  logic [INPUT_W:0]   ctrl_O_top_0_t,
  input  logic [INPUT_W:0]   ctrl_O_top_0_f,
  input  logic [79:0]        key_t,
  input  logic [79:0]        key_f,
  input  logic [79:0]        iv_t,
  input  logic [79:0]        iv_f,
  input  logic               SelfWriteStrobe,
  input  logic [31:0]        SelfWriteData,
  input  logic               Rx,
  input  logic               s_clk,
  input  logic               s_data,
  output logic [INPUT_W:0]   I_top_0_t,
  output logic [INPUT_W:0]   I_top_0_f,
  output logic [INPUT_W:0]   I_top_1_t,
  output logic [INPUT_W:0]   I_top_1_f,
  output logic [INPUT_W:0]   ctrl_I_top_0_t,
  output logic [INPUT_W:0]   ctrl_I_top_0_f,
  output logic [INPUT_W:0]   T_top,
  output logic [INPUT_W:0]   ctrl_T_top,
  output logic [CFG_W-1:0]   A_config_C,
  output logic [CFG_W-1:0]   B_config_C,
  output logic               ComActive,
  output logic               ReceiveLED,
  output logic               f_detected,
  output logic               prech1,
  output logic               prech2
);

  localparam int BW = INPUT_W + 1;

  logic [7:0]        d_p0;
  logic [4:0]        ctrl_p0;
  logic [4:0]        flt_p0;
  logic              fault_p0;
  op_e               op_p0;
  logic [7:0]        t_p0;
  logic [7:0]        acc_nxt_p0;
  logic [BW-1:0]     y_p0;
  logic [BW-1:0]     m_p0;

  logic              phase;
  logic [7:0]        acc;
  logic [LFSR_W-1:0] lfsr_r;
  logic [BW-1:0]     share0_p1;
  logic [BW-1:0]     share1_p1;
  logic [BW-1:0]     stat_p1;
  logic [2*CFG_W-1:0] cfg;

  logic unused_pins;
  assign unused_pins = Rx ^ s_clk ^ s_data;

  // Stage p0: unmask inputs, check rails, compute next accumulator and output word
  assign d_p0    = O_top_0_t[7:0] ^ O_top_1_t[7:0];
  assign ctrl_p0 = ctrl_O_top_0_t[4:0];
  assign op_p0   = op_e'(ctrl_p0[1:0]);

  efpga_dr_check #(.W(BW)) u_chk_o0   (.rail_t(O_top_0_t),      .rail_f(O_top_0_f),      .fault(flt_p0[0]));
  efpga_dr_check #(.W(BW)) u_chk_o1   (.rail_t(O_top_1_t),      .rail_f(O_top_1_f),      .fault(flt_p0[1]));
  efpga_dr_check #(.W(BW)) u_chk_ctrl (.rail_t(ctrl_O_top_0_t), .rail_f(ctrl_O_top_0_f), .fault(flt_p0[2]));
  efpga_dr_check #(.W(80)) u_chk_key  (.rail_t(key_t),          .rail_f(key_f),          .fault(flt_p0[3]));
  efpga_dr_check #(.W(80)) u_chk_iv   (.rail_t(iv_t),           .rail_f(iv_f),           .fault(flt_p0[4]));

  assign fault_p0 = |flt_p0;

  always_comb begin
    t_p0 = acc;
    case (op_p0)
      OP_HOLD: t_p0 = acc;
      OP_LOAD: t_p0 = d_p0;
      OP_ADD:  t_p0 = acc + d_p0;
      OP_XOR:  t_p0 = acc ^ d_p0;
      default: t_p0 = acc;
    endcase
    acc_nxt_p0 = ctrl_p0[2] ? {t_p0[6:0], t_p0[7]} : t_p0;
  end

  always_comb begin
    y_p0                  = '0;
    y_p0[D_LSB +: 8]      = d_p0;
    y_p0[CTRL_LSB +: 4]   = ctrl_p0[3:0];
    y_p0[ACC_LSB +: 8]    = acc;
    y_p0[EN_BIT]          = ctrl_p0[4];
    y_p0[PHASE_BIT]       = phase;
  end

  assign m_p0 = lfsr_r[BW-1:0];

  // Stage p1: datapath state, masked output shares and status
  always_ff @(posedge CLK) begin
    if (rst_sync_fabric) begin
      phase     <= 1'b0;
      acc       <= '0;
      share0_p1 <= '0;
      share1_p1 <= '0;
      stat_p1   <= '0;
    end else begin
      phase <= ~phase;
      if (phase && ctrl_p0[4] && !f_detected)
        acc <= acc_nxt_p0;
      if (f_detected) begin
        share0_p1 <= '0;
        share1_p1 <= '0;
      end else begin
        share0_p1 <= y_p0 ^ m_p0;
        share1_p1 <= m_p0;
      end
      stat_p1 <= {{(BW-7){1'b0}}, f_detected, phase, ctrl_p0};
    end
  end

  always_ff @(posedge CLK) begin
    if (rst_sync_fabric || rst_sync_rng)
      lfsr_r <= lfsr_seed(key_t ^ iv_t);
    else
      lfsr_r <= lfsr_next(lfsr_r);
  end

  always_ff @(posedge CLK) begin
    if (rst_async_full)
      f_detected <= 1'b0;
    else if (fault_p0)
      f_detected <= 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      cfg        <= '0;
      ReceiveLED <= 1'b0;
      ComActive  <= 1'b0;
    end else if (SelfWriteStrobe) begin
      cfg        <= {cfg[2*CFG_W-33:0], SelfWriteData};
      ReceiveLED <= ~ReceiveLED;
      ComActive  <= 1'b1;
    end else begin
      ComActive  <= 1'b0;
    end
  end

  assign I_top_0_t      = share0_p1;
  assign I_top_0_f      = ~share0_p1;
  assign I_top_1_t      = share1_p1;
  assign I_top_1_f      = ~share1_p1;
  assign ctrl_I_top_0_t = stat_p1;
  assign ctrl_I_top_0_f = ~stat_p1;
  assign T_top          = '0;
  assign ctrl_T_top     = '0;
  assign A_config_C     = cfg[CFG_W-1:0];
  assign B_config_C     = cfg[2*CFG_W-1:CFG_W];
  assign prech1         = ~phase;
  assign prech2         = phase;

endmodule

// File: tb/tb_efpga_top2.sv
// Directed self-checking bench for efpga_top2.
module tb_efpga_top2;

  logic        CLK;
  logic        rst_sync_fabric, rst_sync_rng, rst_async_full, resetn;
  logic [22:0] O0t, O1t, C0t;
  logic [79:0] key_t, iv_t, key_flt;
  logic        SelfWriteStrobe;
  logic [31:0] SelfWriteData;
  logic        Rx, s_clk, s_data;
  logic [22:0] O0f, O1f, C0f;
  logic [79:0] key_f, iv_f;
  logic [22:0] I0t, I0f, I1t, I1f, SIt, SIf, T_top, ctrl_T_top;
  logic [91:0] A_config_C, B_config_C;
  logic        ComActive, ReceiveLED, f_detected, prech1, prech2;
  logic [22:0] um;

  int total = 0;
  int bad   = 0;

  assign O0f   = ~O0t;
  assign O1f   = ~O1t;
  assign C0f   = ~C0t;
  assign key_f = ~key_t ^ key_flt;
  assign iv_f  = ~iv_t;
  assign um    = I0t ^ I1t;

  efpga_top2 dut (
    .CLK(CLK), .rst_sync_fabric(rst_sync_fabric), .rst_sync_rng(rst_sync_rng),
    .rst_async_full(rst_async_full), .resetn(resetn),
    .O_top_0_t(O0t), .O_top_0_f(O0f), .O_top_1_t(O1t), .O_top_1_f(O1f),
    .ctrl_O_top_0_t(C0t), .ctrl_O_top_0_f(C0f),
    .key_t(key_t), .key_f(key_f), .iv_t(iv_t), .iv_f(iv_f),
    .SelfWriteStrobe(SelfWriteStrobe), .SelfWriteData(SelfWriteData),
    .Rx(Rx), .s_clk(s_clk), .s_data(s_data),
    .I_top_0_t(I0t), .I_top_0_f(I0f), .I_top_1_t(I1t), .I_top_1_f(I1f),
    .ctrl_I_top_0_t(SIt), .ctrl_I_top_0_f(SIf), .T_top(T_top), .ctrl_T_top(ctrl_T_top),
    .A_config_C(A_config_C), .B_config_C(B_config_C),
    .ComActive(ComActive), .ReceiveLED(ReceiveLED),
    .f_detected(f_detected), .prech1(prech1), .prech2(prech2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [79:0] ref_step(input logic [79:0] r);
    return {r[78:0], r[79] ^ r[78] ^ r[42] ^ r[41]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_data(input logic [22:0] s0, input logic [22:0] s1, input logic [4:0] c);
    O0t = s0;
    O1t = s1;
    C0t = {18'b0, c};
  endtask

  task automatic pulse_fabric();
    rst_sync_fabric = 1'b1;
    tick();
    rst_sync_fabric = 1'b0;
  endtask

  task automatic test_reset();
    rst_sync_fabric = 1'b1; rst_sync_rng = 1'b1; rst_async_full = 1'b1; resetn = 1'b0;
    tick();
    rst_sync_fabric = 1'b0; rst_sync_rng = 1'b0; rst_async_full = 1'b0; resetn = 1'b1;
    total++; if (I0t !== 23'h0 || I1t !== 23'h0) begin bad++; $display("FAIL reset_shares: got %h/%h want 0/0", I0t, I1t); end
    total++; if (I0f !== 23'h7fffff) begin bad++; $display("FAIL reset_share0_f: got %h want 7fffff", I0f); end
    total++; if (SIt !== 23'h0 || SIf !== 23'h7fffff) begin bad++; $display("FAIL reset_status: got %h/%h want 0/7fffff", SIt, SIf); end
    total++; if (f_detected !== 1'b0) begin bad++; $display("FAIL reset_fdet: got %b want 0", f_detected); end
    total++; if (A_config_C !== 92'h0 || B_config_C !== 92'h0) begin bad++; $display("FAIL reset_cfg: got %h/%h want 0", A_config_C, B_config_C); end
    total++; if (ComActive !== 1'b0 || ReceiveLED !== 1'b0) begin bad++; $display("FAIL reset_loader: got %b%b want 00", ComActive, ReceiveLED); end
  endtask

  task automatic test_phase();
    logic e1;
    pulse_fabric();
    e1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (prech1 !== e1 || prech2 !== ~e1) begin bad++; $display("FAIL phase_%0d: got p1=%b p2=%b want p1=%b", i, prech1, prech2, e1); end
      total++; if (T_top !== 23'h0 || ctrl_T_top !== 23'h0) begin bad++; $display("FAIL tristate_%0d: got %h/%h want 0", i, T_top, ctrl_T_top); end
      tick();
      e1 = ~e1;
    end
  endtask

  task automatic test_accum();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h56; exp_seq[1] = 8'h03; exp_seq[2] = 8'h5c;
    pulse_fabric();
    set_data(23'h2b, 23'h0, 5'b01110);
    ticks(2);
    total++; if (um[19:12] !== 8'h00) begin bad++; $display("FAIL accum_disabled: got %h want 00", um[19:12]); end
    C0t[4] = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      ticks(pass == 0 ? 3 : 2);
      for (int k = 0; k < 3; k++) begin
        if (k > 0) ticks(2);
        total++; if (um[19:12] !== exp_seq[k]) begin bad++; $display("FAIL accum_p%0d_%0d: got %h want %h", pass, k, um[19:12], exp_seq[k]); end
      end
      if (pass == 0) begin
        rst_sync_fabric = 1'b1;
        tick();
        rst_sync_fabric = 1'b0;
        total++; if (I0t !== 23'h0 || I1t !== 23'h0) begin bad++; $display("FAIL accum_midreset: got %h/%h want 0/0", I0t, I1t); end
        tick();
        total++; if (um[19:12] !== 8'h00) begin bad++; $display("FAIL accum_after_reset: got %h want 00", um[19:12]); end
      end
    end
  endtask

  task automatic test_load_xor();
    pulse_fabric();
    set_data(23'h700f0, 23'h70055, 5'b10001);
    ticks(3);
    total++; if (um[19:12] !== 8'ha5) begin bad++; $display("FAIL load_a5: got %h want a5", um[19:12]); end
    set_data(23'h0000f0, 23'h0000ff, 5'b10011);
    ticks(2);
    total++; if (um[19:12] !== 8'haa) begin bad++; $display("FAIL xor_aa: got %h want aa", um[19:12]); end
    set_data(23'h0000f0, 23'h0000ff, 5'b10000);
    ticks(2);
    total++; if (um !== 23'h1aa00f) begin bad++; $display("FAIL hold_word: got %h want 1aa00f", um); end
    total++; if (SIt !== 23'h000010) begin bad++; $display("FAIL hold_status: got %h want 000010", SIt); end
    total++; if (I0f !== ~I0t || I1f !== ~I1t) begin bad++; $display("FAIL dual_rail_out: got %h/%h vs %h/%h", I0f, I1f, I0t, I1t); end
  endtask

  task automatic test_mask();
    logic [79:0] r;
    logic [22:0] prev, exp_y;
    logic        ph;
    int          changed;
    key_t = 80'h20a66cfb0a4516cf5e25;
    iv_t  = 80'hf25dec3fd703b7213f16;
    set_data(23'h3c, 23'h0, 5'b00000);
    pulse_fabric();
    r = key_t ^ iv_t;
    ph = 1'b0;
    changed = 0;
    prev = I1t;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_y = {1'b0, ph, 1'b0, 8'h00, 4'h0, 8'h3c};
      total++; if (I1t !== r[22:0]) begin bad++; $display("FAIL mask_m_%0d: got %h want %h", i, I1t, r[22:0]); end
      total++; if (um !== exp_y) begin bad++; $display("FAIL mask_y_%0d: got %h want %h", i, um, exp_y); end
      if (i > 0 && I1t !== prev) changed++;
      prev = I1t;
      r = ref_step(r);
      ph = ~ph;
    end
    total++; if (changed == 0) begin bad++; $display("FAIL mask_changes: got %0d changes want >0", changed); end
  endtask

  task automatic test_fault();
    pulse_fabric();
    set_data(23'h40, 23'h0, 5'b10001);
    ticks(3);
    total++; if (um[19:12] !== 8'h40) begin bad++; $display("FAIL fault_pre: got %h want 40", um[19:12]); end
    set_data(23'h01, 23'h0, 5'b10010);
    key_flt[0] = 1'b1;
    tick();
    total++; if (f_detected !== 1'b1) begin bad++; $display("FAIL fault_set: got %b want 1", f_detected); end
    tick();
    total++; if (I0t !== 23'h0 || I1t !== 23'h0) begin bad++; $display("FAIL fault_zero: got %h/%h want 0/0", I0t, I1t); end
    total++; if (SIt[6] !== 1'b1) begin bad++; $display("FAIL fault_status: got %b want 1", SIt[6]); end
    ticks(4);
    total++; if (f_detected !== 1'b1) begin bad++; $display("FAIL fault_sticky: got %b want 1", f_detected); end
    key_flt = '0;
    rst_async_full = 1'b1;
    tick();
    rst_async_full = 1'b0;
    total++; if (f_detected !== 1'b0) begin bad++; $display("FAIL fault_clear: got %b want 0", f_detected); end
    tick();
    total++; if (um[19:12] !== 8'h41) begin bad++; $display("FAIL fault_frozen: got %h want 41", um[19:12]); end
    ticks(2);
    total++; if (um[19:12] !== 8'h42) begin bad++; $display("FAIL fault_resume: got %h want 42", um[19:12]); end
  endtask

  task automatic test_config();
    logic exp_led;
    resetn = 1'b0;
    SelfWriteStrobe = 1'b1;
    SelfWriteData = 32'hffffffff;
    tick();
    total++; if (A_config_C !== 92'h0 || ReceiveLED !== 1'b0 || ComActive !== 1'b0) begin bad++; $display("FAIL cfg_reset_prio: got %h led=%b com=%b want 0", A_config_C, ReceiveLED, ComActive); end
    resetn = 1'b1;
    exp_led = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_led = ~exp_led;
      total++; if (ReceiveLED !== exp_led || ComActive !== 1'b1) begin bad++; $display("FAIL cfg_strobe_%0d: got led=%b com=%b want led=%b com=1", i, ReceiveLED, ComActive, exp_led); end
    end
    SelfWriteStrobe = 1'b0;
    tick();
    total++; if (ComActive !== 1'b0) begin bad++; $display("FAIL cfg_idle: got %b want 0", ComActive); end
    total++; if (A_config_C !== {92{1'b1}}) begin bad++; $display("FAIL cfg_a: got %h want all ones", A_config_C); end
    total++; if (B_config_C !== 92'hf) begin bad++; $display("FAIL cfg_b: got %h want f", B_config_C); end
    pulse_fabric();
    total++; if (A_config_C !== {92{1'b1}} || B_config_C !== 92'hf || ReceiveLED !== 1'b1) begin bad++; $display("FAIL cfg_fabric_indep: got %h/%h led=%b", A_config_C, B_config_C, ReceiveLED); end
  endtask

  initial begin
    rst_sync_fabric = 1'b0; rst_sync_rng = 1'b0; rst_async_full = 1'b0; resetn = 1'b1;
    O0t = '0; O1t = '0; C0t = '0;
    key_t = '0; iv_t = '0; key_flt = '0;
    SelfWriteStrobe = 1'b0; SelfWriteData = '0;
    Rx = 1'b0; s_clk = 1'b0; s_data = 1'b0;
    #2;
    test_reset();
    test_phase();
    test_accum();
    test_load_xor();
    test_mask();
    test_fault();
    test_config();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/efpga_top2.md
Name: efpga_top2

Overview:
- Simplified, synthesizable model of the SAUBER secure eFPGA top level: a dual-rail, two-share-masked I/O boundary wrapped around a small configurable byte datapath.
- Also contains:
  - a 32-bit-word configuration loader;
  - an 80-bit LFSR mask generator seeded from key/IV;
  - dual-rail fault detection;
  - precharge/evaluate phase generation.
- Sits between the SoC/bench and the fabric array; unmasked result = I_top_0_t ^ I_top_1_t.

Parameters:
- INPUT_W, 22, MSB index of all top I/O buses (bus width INPUT_W+1 = 23).
- CFG_W, 92, width of each of A_config_C / B_config_C.

Ports:
- CLK in 1: single clock.
- rst_sync_fabric in 1: synchronous active-high reset of the datapath, phase, outputs and LFSR reload.
- rst_sync_rng in 1: sync active-high LFSR reload only.
- rst_async_full in 1: sync active-high clear of f_detected (the name is historical; it is sampled on CLK).
- resetn in 1: sync active-low clear of config loader.
- O_top_0_t/_f, O_top_1_t/_f in INPUT_W+1: dual-rail data input shares 0/1.
- ctrl_O_top_0_t/_f in INPUT_W+1: dual-rail control input.
- key_t/_f, iv_t/_f in 80: dual-rail key and IV.
- SelfWriteStrobe in 1, SelfWriteData in 32: config word write.
- Rx, s_clk, s_data in 1: unused, ignored.
- I_top_0_t/_f, I_top_1_t/_f out INPUT_W+1: dual-rail output shares.
- ctrl_I_top_0_t/_f out INPUT_W+1: dual-rail status.
- T_top, ctrl_T_top out INPUT_W+1: tristate enables, constant 0.
- A_config_C, B_config_C out CFG_W: configuration.
- ComActive, ReceiveLED out 1: loader activity.
- f_detected, prech1, prech2 out 1.

Behaviour:
- Every *_f output is the bitwise complement of its *_t output.
- D = (O_top_0_t ^ O_top_1_t)[7:0]; ctrl = ctrl_O_top_0_t[4:0].
- Phase:
  - phase reg resets to 0 and toggles every cycle.
  - prech1 = ~phase; prech2 = phase.
  - An evaluate edge is a rising CLK edge with phase==1.
- Datapath:
  - State: 8-bit acc, reset 0.
  - On an evaluate edge with ctrl[4]==1 and f_detected==0, ctrl[1:0] selects t:
    - 00: t = acc
    - 01: t = D
    - 10: t = acc + D (mod 256)
    - 11: t = acc ^ D
  - Then acc <= ctrl[2] ? {t[6:0], t[7]} : t.
  - ctrl[3] is reserved and ignored.
- LFSR:
  - 80-bit r. Loaded with key_t ^ iv_t on rst_sync_fabric or rst_sync_rng; an all-zero load becomes 80'h1.
  - Otherwise each cycle: r <= {r[78:0], r[79]^r[78]^r[42]^r[41]}.
  - m = r[22:0].
- Output y (23 bits):
  - y[7:0] = D
  - y[11:8] = ctrl[3:0]
  - y[19:12] = acc
  - y[20] = ctrl[4]
  - y[21] = phase
  - y[22] = 0
- Output registers:
  - Every cycle: I_top_0_t <= y ^ m and I_top_1_t <= m.
  - Both are forced to 0 while f_detected==1 or in reset.
  - The unmasked output lags acc by one cycle.
- ctrl_I_top_0_t:
  - Registered {16'b0, f_detected, phase, ctrl[4:0]}.
  - Reset value 0.
- Fault detection:
  - Any bit pair with t==f on O_top_0, O_top_1, ctrl_O_top_0, key or iv sets sticky f_detected on the next edge.
  - f_detected is cleared only by rst_async_full, which takes priority over a new fault.
  - rst_sync_fabric does not clear f_detected.
- Config loader:
  - cfg is a 2*CFG_W shift register.
  - On SelfWriteStrobe: cfg <= {cfg[2*CFG_W-33:0], SelfWriteData}; ReceiveLED toggles; ComActive = 1 for that following cycle.
  - A_config_C = cfg[CFG_W-1:0]; B_config_C = cfg[2*CFG_W-1:CFG_W].
  - resetn==0 clears cfg, ReceiveLED and ComActive, with priority over the strobe.
  - The loader is independent of rst_sync_fabric.
- Reset mid-run: acc and phase return to 0 on the next edge and outputs go to 0; the config contents are untouched.

Decomposition:
- Package efpga_top2_pkg holds:
  - the op encodings OP_HOLD/OP_LOAD/OP_ADD/OP_XOR;
  - LFSR tap constants;
  - the y field offsets (ACC_LSB=12).
- One sub-module is natural: efpga_dr_check, a parameterised dual-rail pair checker producing a fault bit, instantiated per bus.

Test Plan:
- key=iv=0: reset, D=0x2b, ctrl=01110, then ctrl[4]=1 -> unmasked[19:12] sampled every 2 cycles reads 0x56, 0x03, 0x5c; after rst_sync_fabric pulse -> 0x00, then the same sequence again.
- Load then XOR: ctrl=10001 with D=0xA5 -> 0xA5; then ctrl=10011 with D=0x0F -> 0xAA; then ctrl=10000 -> holds 0xAA.
- Masking: key=80'h20a66cfb0a4516cf5e25, iv=80'hf25dec3fd703b7213f16 -> I_top_1_t changes over cycles while the XOR of the shares equals y; I_top_1_t == r[22:0] as computed by the bench's reference model.
- Fault: key_f[0] = key_t[0] -> f_detected=1 one cycle later, both shares 0, acc frozen; restore key_f and pulse rst_async_full -> f_detected=0 and operation resumes.
- Config: resetn low, then three strobes of 0xFFFFFFFF -> A_config_C all ones, B_config_C = 92'hF; ReceiveLED toggles 3 times.
- Phase: after reset prech1=1, prech2=0, alternating every cycle; T_top = ctrl_T_top = 0 throughout.
